// File: rtl/vector_trace_buffer.sv
// Circular trace buffer: captures packed vectors while tracing, then drains them
// oldest-first to the host through a fetch/present handshake. Configured by byte writes.
module vector_trace_buffer #(
  parameter int N                  = 8,
  parameter int DATA_WIDTH         = 32,
  parameter int TB_SIZE            = 4,
  parameter int PERSONAL_CONFIG_ID = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tracing,
  input  logic                          valid_in,
  input  logic [N*DATA_WIDTH-1:0]       vector_in,
  input  logic [7:0]                    configId,
  input  logic [7:0]                    configData,
  input  logic                          ready_in,
  output logic [N*DATA_WIDTH-1:0]       vector_out,
  output logic                          valid_out,
  output logic [$clog2(TB_SIZE):0]      count,
  output logic                          overflow
);

  localparam int VW = N * DATA_WIDTH;
  localparam int PW = $clog2(TB_SIZE);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(TB_SIZE);

  typedef enum logic [1:0] {TRACE, IDLE, FETCH, PRESENT} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            stop_on_full_q, stop_on_full_d;
  logic            valid_out_q, valid_out_d;
  logic [VW-1:0]   vector_out_q, vector_out_d;
  logic            mem_we;
  logic            cfg_hit;
  logic            unused_cfg;
  logic [VW-1:0]   mem [TB_SIZE];

  assign unused_cfg = ^configData[7:2];
  assign cfg_hit    = !tracing && (configId == 8'(PERSONAL_CONFIG_ID));

  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    overflow_d     = overflow_q;
    stop_on_full_d = stop_on_full_q;
    vector_out_d   = vector_out_q;
    mem_we         = 1'b0;

    if (tracing) begin
      state_d = TRACE;
      // Capture only once already in TRACE; the entering cycle is a turnaround.
      if (state_q == TRACE && valid_in) begin
        if (count_q != FULL) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + PW'(1);
          count_d  = count_q + CW'(1);
        end else if (!stop_on_full_q) begin
          mem_we     = 1'b1;
          wr_ptr_d   = wr_ptr_q + PW'(1);
          rd_ptr_d   = rd_ptr_q + PW'(1);
          overflow_d = 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
      end
    end else if (cfg_hit && configData[1]) begin
      // Clear wins over any pop presented in the same cycle.
      stop_on_full_d = configData[0];
      wr_ptr_d       = '0;
      rd_ptr_d       = '0;
      count_d        = '0;
      overflow_d     = 1'b0;
      state_d        = IDLE;
    end else begin
      if (cfg_hit) stop_on_full_d = configData[0];
      unique case (state_q)
        TRACE:   state_d = (count_q != '0) ? FETCH : IDLE;
        IDLE:    if (count_q != '0) state_d = FETCH;
        FETCH: begin
          vector_out_d = mem[rd_ptr_q];
          state_d      = PRESENT;
        end
        PRESENT: begin
          if (ready_in) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            count_d  = count_q - CW'(1);
            state_d  = (count_q > CW'(1)) ? FETCH : IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    valid_out_d = (state_d == PRESENT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      overflow_q     <= 1'b0;
      stop_on_full_q <= 1'b0;
      valid_out_q    <= 1'b0;
      vector_out_q   <= '0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      overflow_q     <= overflow_d;
      stop_on_full_q <= stop_on_full_d;
      valid_out_q    <= valid_out_d;
      vector_out_q   <= vector_out_d;
    end
  end

  // Storage is deliberately not reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q] <= vector_in;
  end

  assign vector_out = vector_out_q;
  assign valid_out  = valid_out_q;
  assign count      = count_q;
  assign overflow   = overflow_q;

endmodule
